// File: rtl/scalar_wb_arbiter.sv
// Writeback arbiter for the scalar register file: two requesters, registered bank/PC write,
// and a pending-write scoreboard. Define WB_ROUND_ROBIN_EN for round-robin arbitration.
module scalar_wb_arbiter #(
  parameter int unsigned bits = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            req0_valid,
  input  logic [3:0]      req0_addr,
  input  logic [bits-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [3:0]      req1_addr,
  input  logic [bits-1:0] req1_data,
  output logic            req1_ready,
  input  logic            alloc_valid,
  input  logic [3:0]      alloc_addr,
  output logic            WE3,
  output logic [3:0]      A3,
  output logic [bits-1:0] WD3,
  output logic            pc_we,
  output logic [bits-1:0] pc_data,
  output logic [15:0]     busy,
  output logic            wb_err
);

  logic            grant0, grant1;
  logic            xfer;
  logic [3:0]      xfer_addr;
  logic [bits-1:0] xfer_data;

`ifdef WB_ROUND_ROBIN_EN
  // ptr_q = 0 gives requester 0 priority on the next contention.
  logic ptr_q, ptr_d;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    ptr_d  = ptr_q;
    if (!RST) begin
      if (req0_valid && req1_valid) begin
        grant0 = ~ptr_q;
        grant1 = ptr_q;
        ptr_d  = ~ptr_q;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Load unit always wins contention.
  always_comb begin
    grant1 = req1_valid & ~RST;
    grant0 = req0_valid & ~req1_valid & ~RST;
  end
`endif

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign xfer       = grant0 | grant1;
  assign xfer_addr  = grant1 ? req1_addr : req0_addr;
  assign xfer_data  = grant1 ? req1_data : req0_data;

  logic            we3_q, we3_d;
  logic [3:0]      a3_q, a3_d;
  logic [bits-1:0] wd3_q, wd3_d;
  logic            pc_we_q, pc_we_d;
  logic [bits-1:0] pc_data_q, pc_data_d;
  logic [15:0]     busy_q, busy_d;
  logic            err_q, err_d;

  always_comb begin
    we3_d     = 1'b0;
    pc_we_d   = 1'b0;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    pc_data_d = pc_data_q;
    busy_d    = busy_q;
    err_d     = err_q;
    if (xfer) begin
      if (xfer_addr == 4'd15) begin
        pc_we_d   = 1'b1;
        pc_data_d = xfer_data;
      end else begin
        we3_d = 1'b1;
        a3_d  = xfer_addr;
        wd3_d = xfer_data;
      end
      busy_d[xfer_addr] = 1'b0;
      if (!busy_q[xfer_addr]) err_d = 1'b1;
    end
    // Allocation applied last so it wins over a same-edge clear.
    if (alloc_valid) busy_d[alloc_addr] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      we3_q     <= 1'b0;
      a3_q      <= 4'd0;
      wd3_q     <= '0;
      pc_we_q   <= 1'b0;
      pc_data_q <= '0;
      busy_q    <= 16'd0;
      err_q     <= 1'b0;
    end else begin
      we3_q     <= we3_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      pc_we_q   <= pc_we_d;
      pc_data_q <= pc_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign WE3     = we3_q;
  assign A3      = a3_q;
  assign WD3     = wd3_q;
  assign pc_we   = pc_we_q;
  assign pc_data = pc_data_q;
  assign busy    = busy_q;
  assign wb_err  = err_q;

endmodule

// File: doc/scalar_wb_arbiter.md
SCALAR_WB_ARBITER -- requirements
Module: scalar_wb_arbiter

Interface
REQ-001 SHALL have parameter: bits, 32, data width of scalar register file write data.
REQ-002 SHALL have port: CLK  input  1  single clock; all state updates on posedge CLK.
REQ-003 SHALL have port: RST  input  1  asynchronous active-high reset.
REQ-004 SHALL have ports: req0_valid, req1_valid  input  1  writeback request from requester 0 (ALU) / 1 (load unit).
REQ-005 SHALL have ports: req0_addr, req1_addr  input  4  destination register.
REQ-006 SHALL have ports: req0_data, req1_data  input  bits  writeback data.
REQ-007 SHALL have ports: req0_ready, req1_ready  output  1  request accepted this cycle (combinational grant).
REQ-008 SHALL have ports: alloc_valid  input  1; alloc_addr  input  4  mark register pending at issue.
REQ-009 SHALL have ports: WE3  output  1; A3  output  4; WD3  output  bits  registered drive of the register bank write port.
REQ-010 SHALL have ports: pc_we  output  1; pc_data  output  bits  registered write of r15 (PC), never routed to bank.
REQ-011 SHALL have ports: busy  output  16  scoreboard, bit n = register n has an outstanding write.
REQ-012 SHALL have port: wb_err  output  1  sticky error flag.

Function
REQ-013 SHALL grant at most one requester per cycle; transfer occurs when reqN_valid and reqN_ready both high.
REQ-014 SHALL drive reqN_ready high only for the granted requester; a lone valid requester is always granted same cycle.
REQ-015 SHALL arbitrate simultaneous requests per Configuration; a loser holds valid/addr/data stable until ready.
REQ-016 SHALL register the granted transfer with latency 1: next cycle WE3=1, A3=addr, WD3=data for addr 0..14.
REQ-017 SHALL, for granted addr 15, assert pc_we=1, pc_data=data next cycle with WE3=0.
REQ-018 SHALL deassert WE3 and pc_we in any cycle following no transfer; A3/WD3/pc_data hold last value.
REQ-019 SHALL set busy[alloc_addr] on posedge when alloc_valid=1.
REQ-020 SHALL clear busy[addr] on posedge following acceptance of a transfer to addr (same edge the transfer is registered).
REQ-021 SHALL, on alloc and clear of the same register on the same edge, leave busy set (alloc wins).
REQ-022 SHALL set wb_err when a transfer is accepted to a register whose busy bit is 0; wb_err remains 1 until reset.
REQ-023 SHALL accept transfers regardless of busy state (scoreboard never stalls requesters).

Reset
REQ-024 SHALL, while RST=1, force WE3=0, A3=0, WD3=0, pc_we=0, pc_data=0, busy=0, wb_err=0, arbiter pointer to requester 0, independent of CLK.
REQ-025 SHALL drive req0_ready=req1_ready=0 while RST=1; a request pending at reset is dropped and must be re-presented.
REQ-026 SHALL resume normal operation on the first posedge after RST deasserts.

Configuration
REQ-027 SHALL use macro WB_ROUND_ROBIN_EN: defined -> round-robin arbitration, pointer toggles to the other requester after each contended grant; requester 0 wins first contention after reset.
REQ-028 SHALL, without WB_ROUND_ROBIN_EN, use fixed priority: requester 1 (load unit) always wins contention; no pointer state.

Verification
REQ-029 SHALL cover: alloc r3, then req0 addr=3 data=0x0000_00AA -> req0_ready=1, next cycle WE3=1 A3=3 WD3=0xAA, busy[3]=0, wb_err=0.
REQ-030 SHALL cover: req0 and req1 both valid (addr 1, 2) for 2 cycles -> RR build: req0 granted then req1; fixed build: req1 granted first, req0 held then granted.
REQ-031 SHALL cover: req1 addr=15 data=0x0000_1000 -> next cycle pc_we=1 pc_data=0x1000, WE3=0.
REQ-032 SHALL cover: alloc_valid addr=5 on same cycle as accepted transfer to r5 (busy[5]=1) -> busy[5]=1 after edge, wb_err=0.
REQ-033 SHALL cover: transfer to r7 with busy[7]=0 -> wb_err=1, stays 1 through further traffic until RST.
REQ-034 SHALL cover: RST asserted mid-contention between posedges -> all outputs 0 immediately, readies 0; after release first contended grant goes to requester 0 (RR) / 1 (fixed).
